// File: rtl/pipeline_flow_ctrl_pkg.sv
// Shared definitions for the pipeline flow controller: FSM state encoding and
// the default HALT drain length.
package pipeline_flow_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HALTED = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_DRAIN  = 2'd3
   } flow_state_e;

   localparam int DRAIN_CYCLES_DEF = 4;
   localparam int DRAIN_CNT_W      = 4;

   // Drain counter start value; the state holds for cnt+1 cycles.
   function automatic logic [DRAIN_CNT_W-1:0] drain_load(input int cycles);
      return DRAIN_CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/pipeline_flow_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (inc_i && (count_q != {WIDTH{1'b1}}))
         count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Pipeline flow controller: stage enables, flush/bubble and the debug
// run/step/halt/drain FSM. Statistics counters exist only with STALL_STATS_EN.
module pipeline_flow_ctrl
   import pipeline_flow_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall_flag,
   input  logic                  reset_control_buses,
   input  logic                  branch_taken,
   input  logic                  halt_instr,
   input  logic                  dbg_run_req,
   input  logic                  dbg_step_req,
   input  logic                  dbg_halt_req,
   input  logic                  dbg_clear_stats,
   output logic                  pipe_enable,
   output logic                  pc_write_en,
   output logic                  ifid_write_en,
   output logic                  ifid_flush,
   output logic                  idex_bubble,
   output logic                  halted,
   output logic                  step_done,
   output logic [DATA_WIDTH-1:0] stall_count,
   output logic [DATA_WIDTH-1:0] flush_count,
   output logic [DATA_WIDTH-1:0] cycle_count
);

   flow_state_e            state_q;
   logic [DRAIN_CNT_W-1:0] drain_cnt_q;
   logic                   halted_q;
   logic                   step_done_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_HALTED;
         drain_cnt_q <= '0;
         halted_q    <= 1'b1;
         step_done_q <= 1'b0;
      end else begin
         step_done_q <= 1'b0;
         case (state_q)
            ST_HALTED: begin
               if (dbg_run_req) begin
                  state_q  <= ST_RUN;
                  halted_q <= 1'b0;
               end else if (dbg_step_req) begin
                  state_q  <= ST_STEP;
                  halted_q <= 1'b0;
               end
            end
            ST_RUN: begin
               if (dbg_halt_req) begin
                  state_q  <= ST_HALTED;
                  halted_q <= 1'b1;
               end else if (halt_instr) begin
                  state_q     <= ST_DRAIN;
                  drain_cnt_q <= drain_load(DRAIN_CYCLES);
               end
            end
            // Debug requests are deliberately not looked at during a step.
            ST_STEP: begin
               if (halt_instr) begin
                  state_q     <= ST_DRAIN;
                  drain_cnt_q <= drain_load(DRAIN_CYCLES);
               end else begin
                  state_q     <= ST_HALTED;
                  halted_q    <= 1'b1;
                  step_done_q <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (dbg_halt_req || (drain_cnt_q == '0)) begin
                  state_q  <= ST_HALTED;
                  halted_q <= 1'b1;
               end else begin
                  drain_cnt_q <= drain_cnt_q - DRAIN_CNT_W'(1);
               end
            end
            default: begin
               state_q  <= ST_HALTED;
               halted_q <= 1'b1;
            end
         endcase
      end
   end

   // Zero-latency qualifiers: a stall blocks the fetch side and overrides a
   // simultaneous branch flush, which simply re-resolves next cycle.
   always_comb begin
      pipe_enable   = 1'b0;
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b0;
      case (state_q)
         ST_RUN, ST_STEP: begin
            pipe_enable   = 1'b1;
            pc_write_en   = !stall_flag;
            ifid_write_en = !stall_flag;
            ifid_flush    = branch_taken && !stall_flag;
            idex_bubble   = stall_flag || reset_control_buses;
         end
         ST_DRAIN: begin
            pipe_enable   = 1'b1;
            ifid_flush    = 1'b1;
            idex_bubble   = stall_flag || reset_control_buses;
         end
         default: ;
      endcase
   end

   assign halted    = halted_q;
   assign step_done = step_done_q;

`ifdef STALL_STATS_EN
   logic stall_inc;
   assign stall_inc = idex_bubble && stall_flag;

   sat_counter #(.WIDTH(DATA_WIDTH)) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (stall_inc),
      .clr_i   (dbg_clear_stats),
      .count_o (stall_count)
   );

   sat_counter #(.WIDTH(DATA_WIDTH)) u_flush_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (ifid_flush),
      .clr_i   (dbg_clear_stats),
      .count_o (flush_count)
   );

   sat_counter #(.WIDTH(DATA_WIDTH)) u_cycle_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (pipe_enable),
      .clr_i   (dbg_clear_stats),
      .count_o (cycle_count)
   );
`else
   logic unused_stats;
   assign unused_stats = dbg_clear_stats;
   assign stall_count  = '0;
   assign flush_count  = '0;
   assign cycle_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Self-checking bench for pipeline_flow_ctrl: directed steps from the test
// plan followed by random traffic, all compared against a behavioural model.
module tb_pipeline_flow_ctrl;

   localparam int DW  = 4;
   localparam int DRN = 4;
   localparam int MAXC = (1 << DW) - 1;

   logic clk = 1'b0;
   logic rst_n, stall_flag, reset_control_buses, branch_taken, halt_instr;
   logic dbg_run_req, dbg_step_req, dbg_halt_req, dbg_clear_stats;
   logic pipe_enable, pc_write_en, ifid_write_en, ifid_flush, idex_bubble;
   logic halted, step_done;
   logic [DW-1:0] stall_count, flush_count, cycle_count;

   always #5 clk = ~clk;

   pipeline_flow_ctrl #(.DATA_WIDTH(DW), .DRAIN_CYCLES(DRN)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .stall_flag          (stall_flag),
      .reset_control_buses (reset_control_buses),
      .branch_taken        (branch_taken),
      .halt_instr          (halt_instr),
      .dbg_run_req         (dbg_run_req),
      .dbg_step_req        (dbg_step_req),
      .dbg_halt_req        (dbg_halt_req),
      .dbg_clear_stats     (dbg_clear_stats),
      .pipe_enable         (pipe_enable),
      .pc_write_en         (pc_write_en),
      .ifid_write_en       (ifid_write_en),
      .ifid_flush          (ifid_flush),
      .idex_bubble         (idex_bubble),
      .halted              (halted),
      .step_done           (step_done),
      .stall_count         (stall_count),
      .flush_count         (flush_count),
      .cycle_count         (cycle_count)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: what the core is doing, not how the RTL encodes it.
   bit m_valid    = 0;
   bit m_running  = 0;
   bit m_stepping = 0;
   int m_drain    = 0;   // drain cycles still to go, 0 = not draining
   bit m_sdone    = 0;
   int m_stall_c  = 0, m_flush_c = 0, m_cycle_c = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v, input bit inc);
      return (inc && v < MAXC) ? v + 1 : v;
   endfunction

   // Drive one cycle of inputs, check mid-cycle, then advance the model.
   task automatic cyc(input bit rn, input bit st, input bit rcb, input bit br,
                      input bit hi, input bit dr, input bit ds, input bit dh,
                      input bit dc);
      bit en, e_pc, e_ifwe, e_fl, e_bub;
      rst_n = rn; stall_flag = st; reset_control_buses = rcb; branch_taken = br;
      halt_instr = hi; dbg_run_req = dr; dbg_step_req = ds; dbg_halt_req = dh;
      dbg_clear_stats = dc;
      #4;
      en = 0; e_pc = 0; e_ifwe = 0; e_fl = 0; e_bub = 0;
      if (m_drain > 0) begin
         en = 1; e_fl = 1; e_bub = st | rcb;
      end else if (m_running || m_stepping) begin
         en = 1; e_pc = !st; e_ifwe = !st; e_fl = br && !st; e_bub = st | rcb;
      end
      if (m_valid) begin
         chk("pipe_enable", 32'(pipe_enable), 32'(en));
         chk("pc_write_en", 32'(pc_write_en), 32'(e_pc));
         chk("ifid_write_en", 32'(ifid_write_en), 32'(e_ifwe));
         chk("ifid_flush", 32'(ifid_flush), 32'(e_fl));
         chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
         chk("halted", 32'(halted), 32'(!en));
         chk("step_done", 32'(step_done), 32'(m_sdone));
`ifdef STALL_STATS_EN
         chk("stall_count", 32'(stall_count), 32'(m_stall_c));
         chk("flush_count", 32'(flush_count), 32'(m_flush_c));
         chk("cycle_count", 32'(cycle_count), 32'(m_cycle_c));
`else
         chk("stall_count", 32'(stall_count), 32'd0);
         chk("flush_count", 32'(flush_count), 32'd0);
         chk("cycle_count", 32'(cycle_count), 32'd0);
`endif
      end
      @(posedge clk);
      #1;
      if (!rn) begin
         m_valid = 1; m_running = 0; m_stepping = 0; m_drain = 0; m_sdone = 0;
         m_stall_c = 0; m_flush_c = 0; m_cycle_c = 0;
      end else begin
         if (dc) begin
            m_stall_c = 0; m_flush_c = 0; m_cycle_c = 0;
         end else begin
            m_stall_c = sat_inc(m_stall_c, e_bub && st);
            m_flush_c = sat_inc(m_flush_c, e_fl);
            m_cycle_c = sat_inc(m_cycle_c, en);
         end
         m_sdone = 0;
         if (m_drain > 0) begin
            m_drain = dh ? 0 : m_drain - 1;
         end else if (m_stepping) begin
            m_stepping = 0;
            if (hi) m_drain = DRN;
            else    m_sdone = 1;
         end else if (m_running) begin
            if (dh) m_running = 0;
            else if (hi) begin m_running = 0; m_drain = DRN; end
         end else begin
            if (dr) m_running = 1;
            else if (ds) m_stepping = 1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      @(posedge clk); #1;
      // reset, then quiet for 10 cycles
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(10);
      chk("idle_halted", 32'(halted), 32'd1);
      // run, two stall cycles
      cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
`ifdef STALL_STATS_EN
      chk("stall_two", 32'(stall_count), 32'd2);
`endif
      // stall beats branch, then branch alone flushes
      cyc(1, 1, 0, 1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0, 0, 0, 0, 0);
      // freeze, single step, then run+step together
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(2);
      cyc(1, 0, 0, 1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("step_pulse", 32'(step_done), 32'd1);
      idle(2);
      cyc(1, 0, 0, 0, 0, 1, 1, 0, 0);
      idle(3);
      // HALT instruction drain, then reset mid-drain
      cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(DRN + 2);
      cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(2);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // step into a HALT instruction: drain, no step_done
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(DRN + 2);
      // drain aborted by debug halt
      cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(2);
      // saturation: 20 stalls, then clear
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef STALL_STATS_EN
      chk("stall_sat", 32'(stall_count), 32'd15);
`endif
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      chk("clear_stats", 32'(stall_count), 32'd0);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 149) != 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 14) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
